// File: rtl/eth_frame_serializer_if.sv
// Parallel frame bundle in, byte stream out, plus status. The master side is
// the packet generator / sink environment; the slave side is the serializer.
interface eth_frame_serializer_if #(
    parameter int MAX_PAY = 64
);
    // Parallel frame side
    logic                   frm_valid;
    logic                   frm_ready;
    logic [55:0]            preamble;
    logic [7:0]             sfd;
    logic [47:0]            da;
    logic [47:0]            sa;
    logic [15:0]            len;
    logic [8*MAX_PAY-1:0]   payload;
    logic [31:0]            crc;

    // Byte stream side
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   tx_sop;
    logic                   tx_eop;

    // Status
    logic                   len_err;
    logic [15:0]            frm_cnt;

    modport master (
        output frm_valid, preamble, sfd, da, sa, len, payload, crc, tx_ready,
        input  frm_ready, tx_data, tx_valid, tx_sop, tx_eop, len_err, frm_cnt
    );

    modport slave (
        input  frm_valid, preamble, sfd, da, sa, len, payload, crc, tx_ready,
        output frm_ready, tx_data, tx_valid, tx_sop, tx_eop, len_err, frm_cnt
    );
endinterface

// File: rtl/eth_frame_serializer.sv
// Serializes one captured Ethernet frame (preamble, SFD, DA, SA, length,
// clamped payload, CRC) into a byte-wide valid/ready stream, MSB byte first
// within every field. The CRC is forwarded untouched.
module eth_frame_serializer #(
    parameter int MAX_PAY = 64
) (
    input  logic                    clk,
    input  logic                    rst,   // synchronous, active-low
    eth_frame_serializer_if.slave   bus
);
    localparam int PW = 8 * MAX_PAY;

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DA, SA, LEN, PAY, CRC
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     cnt_q, cnt_d;      // byte index within the current field
    logic [6:0]     last_idx;          // index of the current field's last byte

    // Shadow copies of the frame; each multi-byte field shifts left as it is
    // sent so its top byte is always the one on the wire.
    logic [55:0]    pre_q;
    logic [7:0]     sfd_q;
    logic [47:0]    da_q;
    logic [47:0]    sa_q;
    logic [15:0]    len_q;
    logic [PW-1:0]  pay_q;
    logic [31:0]    crc_q;
    logic [6:0]     plen_q;            // clamped payload byte count P

    logic           capture;
    logic           fire;
    logic           over_len;
    logic           frm_ready_c;
    logic           tx_valid_c;
    logic           tx_sop_c;
    logic           tx_eop_c;
    logic [7:0]     tx_byte;
    logic           len_err_q;
    logic [15:0]    frm_cnt_q;

    assign over_len = bus.len > 16'(MAX_PAY);
    assign capture  = frm_ready_c && bus.frm_valid;
    assign fire     = tx_valid_c && bus.tx_ready;

    // Next-state, byte select and stream qualifiers for the field sequencer.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frm_ready_c = 1'b0;
        tx_valid_c  = 1'b0;
        tx_byte     = 8'h00;
        last_idx    = 7'd0;

        case (state_q)
            IDLE: begin
                frm_ready_c = 1'b1;
                if (bus.frm_valid) begin
                    state_d = PRE;
                    cnt_d   = 7'd0;
                end
            end
            PRE: begin
                tx_byte  = pre_q[55:48];
                last_idx = 7'd6;
            end
            SFD: begin
                tx_byte  = sfd_q;
                last_idx = 7'd0;
            end
            DA: begin
                tx_byte  = da_q[47:40];
                last_idx = 7'd5;
            end
            SA: begin
                tx_byte  = sa_q[47:40];
                last_idx = 7'd5;
            end
            LEN: begin
                tx_byte  = len_q[15:8];
                last_idx = 7'd1;
            end
            PAY: begin
                tx_byte  = pay_q[PW-1 -: 8];
                last_idx = plen_q - 7'd1;  // PAY is only entered with P > 0
            end
            CRC: begin
                tx_byte  = crc_q[31:24];
                last_idx = 7'd3;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            tx_valid_c = 1'b1;
            if (bus.tx_ready) begin
                if (cnt_q == last_idx) begin
                    cnt_d = 7'd0;
                    case (state_q)
                        PRE:     state_d = SFD;
                        SFD:     state_d = DA;
                        DA:      state_d = SA;
                        SA:      state_d = LEN;
                        LEN:     state_d = (plen_q == 7'd0) ? CRC : PAY;
                        PAY:     state_d = CRC;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
        end
    end

    assign tx_sop_c = (state_q == PRE) && (cnt_q == 7'd0);
    assign tx_eop_c = (state_q == CRC) && (cnt_q == 7'd3);

    // Control state: sequencer, length-error pulse and sent-frame counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 7'd0;
            len_err_q <= 1'b0;
            frm_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_err_q <= capture && over_len;
            if (fire && tx_eop_c) begin
                frm_cnt_q <= frm_cnt_q + 16'd1;
            end
        end
    end

    // Shadow field registers: load on capture, shift out as bytes are taken.
    // NOTE: this datapath carries no reset; it is only observed once the
    // sequencer leaves IDLE, which always follows a fresh load.
    always_ff @(posedge clk) begin
        if (capture) begin
            pre_q  <= bus.preamble;
            sfd_q  <= bus.sfd;
            da_q   <= bus.da;
            sa_q   <= bus.sa;
            len_q  <= bus.len;
            pay_q  <= bus.payload;
            crc_q  <= bus.crc;
            plen_q <= over_len ? 7'(MAX_PAY) : bus.len[6:0];
        end else if (fire) begin
            case (state_q)
                PRE:     pre_q <= {pre_q[47:0], 8'h00};
                DA:      da_q  <= {da_q[39:0], 8'h00};
                SA:      sa_q  <= {sa_q[39:0], 8'h00};
                LEN:     len_q <= {len_q[7:0], 8'h00};
                PAY:     pay_q <= {pay_q[PW-9:0], 8'h00};
                CRC:     crc_q <= {crc_q[23:0], 8'h00};
                default: ;
            endcase
        end
    end

    assign bus.frm_ready = frm_ready_c;
    assign bus.tx_valid  = tx_valid_c;
    assign bus.tx_data   = tx_byte;
    assign bus.tx_sop    = tx_sop_c;
    assign bus.tx_eop    = tx_eop_c;
    assign bus.len_err   = len_err_q;
    assign bus.frm_cnt   = frm_cnt_q;
endmodule

// File: tb/tb_eth_frame_serializer.sv
// Directed bench for eth_frame_serializer: builds each frame's expected byte
// stream from its fields and compares it byte by byte while varying tx_ready.
module tb_eth_frame_serializer;
    localparam int MAX_PAY = 64;

    typedef struct packed {
        logic [55:0]  pre;
        logic [7:0]   sfd;
        logic [47:0]  da;
        logic [47:0]  sa;
        logic [15:0]  len;
        logic [511:0] pay;
        logic [31:0]  crc;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_frame_serializer_if #(.MAX_PAY(MAX_PAY)) bus ();

    eth_frame_serializer #(.MAX_PAY(MAX_PAY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         checks  = 0;
    int         errors  = 0;
    int         exp_cnt = 0;
    logic [7:0] exp_q[$];
    frame_t     f;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference stream: fields in order, MSB byte first, payload clamped to 64.
    task automatic build(input frame_t fr);
        int p;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(fr.pre[55-8*i -: 8]);
        exp_q.push_back(fr.sfd);
        for (int i = 0; i < 6; i++) exp_q.push_back(fr.da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(fr.sa[47-8*i -: 8]);
        exp_q.push_back(fr.len[15:8]);
        exp_q.push_back(fr.len[7:0]);
        p = (fr.len > 16'd64) ? 64 : int'(fr.len);
        for (int i = 0; i < p; i++) exp_q.push_back(fr.pay[511-8*i -: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fr.crc[31-8*i -: 8]);
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on sop and eop.
    // abort_at >= 0 pulls reset low while that byte index is presented.
    task automatic run_frame(input frame_t fr, input int mode, input int abort_at, input bit b2b);
        int idx, n, cyc, stall;
        logic rdy;
        build(fr);
        n   = exp_q.size();
        cyc = 0;
        while (bus.frm_ready !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("frm_ready_idle", bus.frm_ready, 1);
        if (b2b) check("b2b_no_extra_wait", cyc, 0);

        bus.preamble  = fr.pre;
        bus.sfd       = fr.sfd;
        bus.da        = fr.da;
        bus.sa        = fr.sa;
        bus.len       = fr.len;
        bus.payload   = fr.pay;
        bus.crc       = fr.crc;
        bus.frm_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs: the DUT must be working from its shadow copy.
        bus.frm_valid = 1'b0;
        bus.preamble  = ~fr.pre;
        bus.sfd       = ~fr.sfd;
        bus.da        = ~fr.da;
        bus.sa        = ~fr.sa;
        bus.len       = ~fr.len;
        bus.payload   = ~fr.pay;
        bus.crc       = ~fr.crc;
        check("len_err_pulse", bus.len_err, (fr.len > 16'd64));

        idx   = 0;
        cyc   = 0;
        stall = 0;
        while (idx < n) begin
            if (cyc >= 3000) begin
                check("frame_timeout_bytes_sent", idx, n);
                break;
            end
            if (abort_at == idx) begin
                rst = 1'b0;
                @(posedge clk); #1;
                check("abort_tx_valid", bus.tx_valid, 0);
                check("abort_tx_eop", bus.tx_eop, 0);
                check("abort_frm_cnt", bus.frm_cnt, 0);
                exp_cnt = 0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                check("abort_frm_ready", bus.frm_ready, 1);
                check("abort_idle_valid", bus.tx_valid, 0);
                return;
            end
            check("tx_valid", bus.tx_valid, 1);
            check($sformatf("tx_data[%0d]", idx), bus.tx_data, exp_q[idx]);
            check($sformatf("tx_sop[%0d]", idx), bus.tx_sop, (idx == 0));
            check($sformatf("tx_eop[%0d]", idx), bus.tx_eop, (idx == n - 1));
            check("frm_ready_busy", bus.frm_ready, 0);
            if (cyc == 1) check("len_err_single", bus.len_err, 0);
            case (mode)
                1:       rdy = ($urandom_range(0, 99) < 60);
                2:       if ((idx == 0 || idx == n - 1) && stall < 5) begin
                             rdy = 1'b0;
                             stall++;
                         end else begin
                             rdy = 1'b1;
                         end
                default: rdy = 1'b1;
            endcase
            bus.tx_ready = rdy;
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin
                idx++;
                stall = 0;
            end
        end
        bus.tx_ready = 1'b1;
        if (idx == n) exp_cnt++;
        check("frm_cnt", bus.frm_cnt, exp_cnt);
        check("bubble_tx_valid", bus.tx_valid, 0);
        check("bubble_frm_ready", bus.frm_ready, 1);
    endtask

    initial begin
        rst           = 1'b0;
        bus.frm_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.preamble  = '0;
        bus.sfd       = '0;
        bus.da        = '0;
        bus.sa        = '0;
        bus.len       = '0;
        bus.payload   = '0;
        bus.crc       = '0;

        // Reset held low for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_tx_sop", bus.tx_sop, 0);
        check("rst_tx_eop", bus.tx_eop, 0);
        check("rst_len_err", bus.len_err, 0);
        check("rst_frm_cnt", bus.frm_cnt, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_release_frm_ready", bus.frm_ready, 1);

        // Basic 30-byte frame.
        f.pre = 56'h55555555555555;
        f.sfd = 8'hD5;
        f.da  = 48'h112233445566;
        f.sa  = 48'hAABBCCDDEEFF;
        f.len = 16'd4;
        f.pay = {32'hDEADBEEF, 480'd0};
        f.crc = 32'h01020304;
        run_frame(f, 0, -1, 1'b0);

        // Full 64-byte payload, then a back-to-back frame.
        for (int i = 0; i < 64; i++) f.pay[511-8*i -: 8] = 8'(i * 3 + 1);
        f.len = 16'd64;
        run_frame(f, 0, -1, 1'b0);
        f.crc = 32'hCAFEF00D;
        f.da  = 48'h0A0B0C0D0E0F;
        run_frame(f, 0, -1, 1'b1);

        // Over-long length is clamped; the LEN bytes still carry 00 64.
        f.len = 16'd100;
        run_frame(f, 0, -1, 1'b0);

        // Zero-length payload: LEN is followed directly by CRC.
        f.len = 16'd0;
        f.crc = 32'h89ABCDEF;
        run_frame(f, 0, -1, 1'b0);

        // Five-cycle stalls on the sop and eop bytes.
        f.len = 16'd7;
        run_frame(f, 2, -1, 1'b0);

        // Clear the counter, then 20 frames under random backpressure.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 0;
        check("cnt_cleared", bus.frm_cnt, 0);
        for (int k = 0; k < 20; k++) begin
            f.len = 16'($urandom_range(0, 70));
            for (int i = 0; i < 16; i++) f.pay[511-32*i -: 32] = $urandom;
            f.crc = $urandom;
            f.sa  = {16'hA5A5, 32'($urandom)};
            run_frame(f, 1, -1, 1'b0);
        end
        check("frm_cnt_after_random", bus.frm_cnt, 20);

        // Reset while payload byte 10 (stream index 32) is on the wire.
        f.len = 16'd20;
        run_frame(f, 0, 32, 1'b0);

        // A clean frame after the abort.
        f.len = 16'd4;
        run_frame(f, 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_frame_serializer.md
# eth_frame_serializer

Converts one parallel Ethernet frame (preamble, SFD, DA, SA, length, up to 64-byte payload, CRC) into a byte-wide transmit stream with valid/ready flow control. It sits directly downstream of the packet generator that drives the parallel `eth_if` field bundle. It feeds the byte-level MAC/PHY model and monitor. CRC is passed through unchanged; the serializer does not compute or check it.

## Interface
- `MAX_PAY`, 64: maximum payload bytes; must equal the payload width divided by 8.
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous reset, active-low.
- `frm_valid`  input  1  the parallel frame fields are valid.
- `frm_ready`  output  1  the block accepts a frame this cycle.
- `preamble`  input  56  preamble field.
- `sfd`  input  8  start-of-frame delimiter.
- `da`  input  48  destination address.
- `sa`  input  48  source address.
- `len`  input  16  payload length in bytes.
- `payload`  input  512  payload; byte 0 is `payload[511:504]`.
- `crc`  input  32  frame check sequence, sent as given.
- `tx_data`  output  8  current stream byte.
- `tx_valid`  output  1  `tx_data` is valid.
- `tx_ready`  input  1  the sink accepts the byte.
- `tx_sop`  output  1  high with the first preamble byte.
- `tx_eop`  output  1  high with the last CRC byte.
- `len_err`  output  1  one-cycle pulse on capture when `len` > `MAX_PAY`.
- `frm_cnt`  output  16  count of frames fully sent; wraps at 0xFFFF→0.

## Operation
- **Capture**
  - A frame is captured when `frm_valid && frm_ready`.
  - All fields are registered into shadow registers, so the inputs may change freely afterwards.
- **Payload byte count P**
  - P = `len` when `len` ≤ `MAX_PAY`.
  - Otherwise P = `MAX_PAY` and `len_err` pulses in the cycle after capture.
  - `len` = 0 gives P = 0: no payload bytes are sent.
- **Field order** (within each field, most-significant byte first)
  1. preamble: 7 bytes
  2. sfd: 1 byte
  3. da: 6 bytes
  4. sa: 6 bytes
  5. len: 2 bytes, the original `len` value, not the clamped P
  6. payload: P bytes
  7. crc: 4 bytes
- Total bytes per frame = 26 + P.
- **States:** IDLE, PRE, SFD, DA, SA, LEN, PAY, CRC.
  - A byte counter (7 bits) indexes within the current field.
  - The state moves to the next field on the handshake of the field's last byte.
  - PAY is skipped when P = 0 (LEN goes straight to CRC).
  - CRC returns to IDLE.
- **Output handshake**
  - A byte transfers when `tx_valid && tx_ready`.
  - While `tx_valid && !tx_ready`: `tx_data`, `tx_sop` and `tx_eop` hold stable, and the state and counter do not advance.
  - `tx_valid` never drops mid-frame.
- `frm_ready` = 1 only in IDLE; it is 0 from the capture cycle until the return to IDLE.
- `frm_cnt` increments on the handshake of the `tx_eop` byte.

## Timing
- **Reset**
  - While `rst` is sampled low on an edge, the block enters IDLE in that cycle.
  - Outputs after reset: `tx_valid`=0, `tx_data`=0x00, `tx_sop`=0, `tx_eop`=0, `len_err`=0, `frm_cnt`=0.
  - `frm_ready`=1 from the first cycle after reset release.
- **Reset mid-frame:** the frame is aborted. `tx_valid` falls in the next cycle and no `tx_eop` is produced.
- **Latency:** frame accepted at edge N gives the first byte (`tx_valid`=1, `tx_sop`=1) registered at N+1.
- **Throughput:** with `tx_ready` held high, one byte per cycle.
- **Last byte to IDLE:** the last-byte handshake at edge M puts the block in IDLE at M+1 with `frm_ready`=1.
  - The earliest next capture is edge M+1, and its first byte appears at M+2.
  - This gives exactly one bubble cycle between back-to-back frames.
- **`tx_ready` stalls:** a `tx_ready` deassertion on any byte, including `tx_sop` and `tx_eop` bytes, stretches that byte with no loss or duplication.
- `frm_valid` asserted while `frm_ready`=0 is ignored; the upstream holds it.

## Test plan
- **Basic frame:** reset low 3 cycles, then capture with preamble=0x55555555555555, sfd=0xD5, da=0x112233445566, sa=0xAABBCCDDEEFF, len=4, payload[511:480]=0xDEADBEEF, crc=0x01020304.
  - Expect 30 bytes: 55×7, D5, 11..66, AA..FF, 00 04, DE AD BE EF, 01 02 03 04.
  - `tx_sop` on byte 0, `tx_eop` on byte 29, `frm_cnt`=1.
- **Full payload:** len=64 → 90 bytes.
  - Payload bytes equal `payload[511:0]` taken MSB-first.
  - Back-to-back second frame: first byte 2 cycles after the last-byte handshake.
- **Clamp and zero length**
  - len=100: `len_err` pulses once, 64 payload bytes are sent, and the LEN bytes are 00 64.
  - len=0: 26 bytes, with the LEN bytes followed directly by the CRC bytes.
- **Random backpressure:** toggle `tx_ready` randomly over 20 frames.
  - Each frame's byte stream matches the reference model.
  - Bytes are held stable while stalled; `frm_cnt`=20.
- **Stall on markers:** hold `tx_ready`=0 for 5 cycles on the `tx_sop` byte and on the `tx_eop` byte.
  - Each marker stays high for the whole stall and is sent exactly once.
- **Reset mid-payload:** drive `rst`=0 at payload byte 10.
  - `tx_valid`=0 next cycle, no `tx_eop`, `frm_cnt` returns to 0, and `frm_ready`=1 after release.
